// File: rtl/multicycle_sequencer_if.sv
// Instruction/data memory handshake bundle between the sequencer (master)
// and the memory side (slave).
interface multicycle_sequencer_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_ack;
    logic mem_write_en;

    modport master (
        output imem_req,
        output dmem_req,
        output mem_write_en,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  mem_write_en,
        output imem_ack,
        output dmem_ack
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: FETCH/DECODE/EXECUTE/MEM/WB sequencing with memory
// acknowledge timeouts and a wrapping retired-instruction counter.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          stop_req,
    input  logic [2:0]                    opcode,
    multicycle_sequencer_if.master        mem,
    output logic                          ir_load,
    output logic                          pc_en,
    output logic                          alu_en,
    output logic                          reg_write_en,
    output logic                          result_src,
    output logic                          busy,
    output logic                          halted,
    output logic                          err,
    output logic [CNT_W-1:0]              retire_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_HALTED,
        S_ERROR
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [2:0]         op_q, op_d;
    logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
    logic               retire;
    logic               waiting;
    logic               timed_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            op_q         <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            op_q         <= op_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // The wait counter is only nonzero while stalled in FETCH/MEM, so every
    // entry into those states starts from zero without an explicit clear.
    always_comb begin
        waiting   = ((state_q == S_FETCH) && !mem.imem_ack) ||
                    ((state_q == S_MEM)   && !mem.dmem_ack);
        timed_out = waiting && (wait_cnt_q == WAIT_LIMIT);
        if (waiting && !timed_out) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
            wait_cnt_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem.imem_ack)   state_d = S_DECODE;
                else if (timed_out) state_d = S_ERROR;
            end
            S_DECODE: begin
                op_d    = opcode;
                state_d = (opcode == OP_HALT) ? S_HALTED : S_EXECUTE;
            end
            S_EXECUTE: begin
                if ((op_q == OP_LOAD) || (op_q == OP_STORE)) state_d = S_MEM;
                else                                         state_d = S_WB;
            end
            S_MEM: begin
                if (mem.dmem_ack) begin
                    if (op_q == OP_STORE) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALTED: begin
                if (start) state_d = S_FETCH;
            end
            S_ERROR: begin
                if (start) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
        if (retire && stop_req) state_d = S_IDLE;
    end

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (retire) retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end

    // result_src idles at ALU, but is gated by reset so every output is low
    // while rst_n is asserted.
    assign mem.imem_req     = (state_q == S_FETCH);
    assign ir_load          = (state_q == S_FETCH) && mem.imem_ack;
    assign pc_en            = (state_q == S_FETCH) && mem.imem_ack;
    assign alu_en           = (state_q == S_EXECUTE);
    assign mem.dmem_req     = (state_q == S_MEM);
    assign mem.mem_write_en = (state_q == S_MEM) && (op_q == OP_STORE);
    assign reg_write_en     = (state_q == S_WB);
    assign result_src       = rst_n && !((state_q == S_WB) && (op_q == OP_LOAD));
    assign busy             = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                              (state_q == S_EXECUTE) || (state_q == S_MEM) ||
                              (state_q == S_WB);
    assign halted           = (state_q == S_HALTED);
    assign err              = (state_q == S_ERROR);
    assign retire_cnt       = retire_cnt_q;

endmodule
